// File: rtl/uc_prog_loader_if.sv
// Byte-stream receive handshake plus the core memory write port of the program loader.
// master drives bytes and observes writes; slave is the loader itself.
interface uc_prog_loader_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic [7:0] mem_addr;
  logic       mem_write_en;
  logic [7:0] mem_data;

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  mem_addr,
    input  mem_write_en,
    input  mem_data
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output mem_addr,
    output mem_write_en,
    output mem_data
  );
endinterface

// File: rtl/uc_prog_loader.sv
// Framed program loader (HEADER, LEN, data, CSUM) writing core memory; write strobe 1 cycle after each data byte.
// Accepts one byte per cycle until the image checks out, then deasserts rx_ready and releases the core from reset.
module uc_prog_loader #(
  parameter logic [7:0]  BASE_ADDR = 8'h00,
  parameter logic [7:0]  HEADER    = 8'hA5,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic              clk,
  input  logic              arst_n,
  uc_prog_loader_if.slave   bus,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [8:0] cnt, cnt_nxt;
  logic [7:0] idx, idx_nxt;
  logic [7:0] acc, acc_nxt;
  logic [15:0] tcnt, tcnt_nxt;

  logic       rx_ready_q;
  logic [7:0] addr_q, addr_nxt;
  logic [7:0] data_q, data_nxt;
  logic       wen_q, wen_nxt;
  logic       core_rst_q, done_q, err_q;

  logic       hs;
  logic       running;
  logic       tmo_hit;
  logic [7:0] sum8;

  assign hs      = bus.rx_valid && rx_ready_q;
  assign running = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  assign tmo_hit = running && !hs && (tcnt == TMO_LAST);
  assign sum8    = acc + bus.rx_data;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    acc_nxt   = acc;
    addr_nxt  = addr_q;
    data_nxt  = data_q;
    wen_nxt   = 1'b0;
    tcnt_nxt  = (hs || !running) ? 16'd0 : tcnt + 16'd1;

    case (state)
      S_IDLE, S_ERR: begin
        if (hs && bus.rx_data == HEADER) state_nxt = S_LEN;
      end
      S_LEN: begin
        if (hs) begin
          // a zero length field encodes a full 256-byte image
          cnt_nxt   = (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
          idx_nxt   = 8'h00;
          acc_nxt   = 8'h00;
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (hs) begin
          wen_nxt  = 1'b1;
          addr_nxt = BASE_ADDR + idx;
          data_nxt = bus.rx_data;
          idx_nxt  = idx + 8'd1;
          acc_nxt  = sum8;
          cnt_nxt  = cnt - 9'd1;
          if (cnt == 9'd1) state_nxt = S_CSUM;
        end
      end
      S_CSUM: begin
        if (hs) state_nxt = (sum8 == 8'h00) ? S_DONE : S_ERR;
      end
      default: ;
    endcase

    // an idle link inside a frame abandons it; writes already issued stay in memory
    if (tmo_hit) state_nxt = S_ERR;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      acc        <= '0;
      tcnt       <= '0;
      rx_ready_q <= 1'b0;
      addr_q     <= BASE_ADDR;
      data_q     <= '0;
      wen_q      <= 1'b0;
      core_rst_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      acc        <= acc_nxt;
      tcnt       <= tcnt_nxt;
      rx_ready_q <= (state_nxt != S_DONE);
      addr_q     <= addr_nxt;
      data_q     <= data_nxt;
      wen_q      <= wen_nxt;
      core_rst_q <= (state_nxt == S_DONE);
      done_q     <= (state_nxt == S_DONE);
      err_q      <= (state_nxt == S_ERR);
    end
  end

  assign bus.rx_ready     = rx_ready_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_write_en = wen_q;
  assign bus.mem_data     = data_q;
  assign core_rst_n       = core_rst_q;
  assign load_done        = done_q;
  assign load_err         = err_q;

endmodule

// File: tb/tb_uc_prog_loader.sv
// Bench for uc_prog_loader: two instances (base 00/timeout 10, base 80/timeout 1000) share one byte driver,
// and a byte-level frame interpreter predicts writes, their cycles and the final status.
module tb_uc_prog_loader;

  localparam int P_HUNT = 0;
  localparam int P_LEN  = 1;
  localparam int P_DATA = 2;
  localparam int P_CSUM = 3;
  localparam int P_DONE = 4;
  localparam int P_ERR  = 5;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  uc_prog_loader_if if_a ();
  uc_prog_loader_if if_b ();
  logic core_rst_n_a, load_done_a, load_err_a;
  logic core_rst_n_b, load_done_b, load_err_b;

  uc_prog_loader #(.BASE_ADDR(8'h00), .HEADER(8'hA5), .TIMEOUT(10)) dut_a (
    .clk(clk), .arst_n(arst_n), .bus(if_a),
    .core_rst_n(core_rst_n_a), .load_done(load_done_a), .load_err(load_err_a)
  );

  uc_prog_loader #(.BASE_ADDR(8'h80), .HEADER(8'hA5), .TIMEOUT(1000)) dut_b (
    .clk(clk), .arst_n(arst_n), .bus(if_b),
    .core_rst_n(core_rst_n_b), .load_done(load_done_b), .load_err(load_err_b)
  );

  logic       sel;
  logic       drv_valid;
  logic [7:0] drv_data;

  assign if_a.rx_valid = drv_valid && !sel;
  assign if_a.rx_data  = drv_data;
  assign if_b.rx_valid = drv_valid && sel;
  assign if_b.rx_data  = drv_data;

  logic       cur_ready, cur_wen, cur_done, cur_err, cur_crst;
  logic [7:0] cur_addr, cur_data;
  assign cur_ready = sel ? if_b.rx_ready     : if_a.rx_ready;
  assign cur_wen   = sel ? if_b.mem_write_en : if_a.mem_write_en;
  assign cur_addr  = sel ? if_b.mem_addr     : if_a.mem_addr;
  assign cur_data  = sel ? if_b.mem_data     : if_a.mem_data;
  assign cur_done  = sel ? load_done_b       : load_done_a;
  assign cur_err   = sel ? load_err_b        : load_err_a;
  assign cur_crst  = sel ? core_rst_n_b      : core_rst_n_a;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  wr_t act_q[$];
  wr_t exp_q[$];
  int  stray = 0;
  int  act_rd = 0;
  int  stray_base = 0;

  always @(negedge clk) begin
    wr_t w;
    if (if_a.mem_write_en === 1'b1) begin
      w.addr = if_a.mem_addr; w.data = if_a.mem_data; w.cyc = cyc;
      if (!sel) act_q.push_back(w); else stray++;
    end
    if (if_b.mem_write_en === 1'b1) begin
      w.addr = if_b.mem_addr; w.data = if_b.mem_data; w.cyc = cyc;
      if (sel) act_q.push_back(w); else stray++;
    end
  end

  int tests = 0;
  int fails = 0;

  // frame interpreter state
  int m_phase, m_left, m_idx, m_sum, m_last, m_base, m_tmo;
  int last_hs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkb(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic in_frame();
    return (m_phase == P_LEN) || (m_phase == P_DATA) || (m_phase == P_CSUM);
  endfunction

  function automatic void model_byte(input logic [7:0] b, input int hs);
    wr_t w;
    if (in_frame() && (hs - 1 - m_last) >= m_tmo) m_phase = P_ERR;
    m_last = hs;
    case (m_phase)
      P_HUNT, P_ERR: if (b == 8'hA5) m_phase = P_LEN;
      P_LEN: begin
        m_left  = (b == 8'h00) ? 256 : int'(b);
        m_idx   = 0;
        m_sum   = 0;
        m_phase = P_DATA;
      end
      P_DATA: begin
        w.addr = 8'((m_base + m_idx) % 256);
        w.data = b;
        w.cyc  = hs;
        exp_q.push_back(w);
        m_idx++;
        m_sum = (m_sum + int'(b)) % 256;
        m_left--;
        if (m_left == 0) m_phase = P_CSUM;
      end
      P_CSUM: m_phase = (((m_sum + int'(b)) % 256) == 0) ? P_DONE : P_ERR;
      default: ;
    endcase
  endfunction

  function automatic void model_settle();
    if (in_frame() && (cyc - m_last) >= m_tmo) m_phase = P_ERR;
  endfunction

  task automatic model_reset(input logic s);
    m_phase = P_HUNT;
    m_base  = s ? 8'h80 : 8'h00;
    m_tmo   = s ? 1000 : 10;
    m_last  = 0;
  endtask

  task automatic do_reset(input logic s);
    @(negedge clk);
    drv_valid = 1'b0;
    #1;
    arst_n = 1'b0;
    sel = s;
    model_reset(s);
    exp_q.delete();
    act_rd = act_q.size();
    stray_base = stray;
    @(negedge clk);
    #1;
    arst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int hs;
    repeat (gap) @(negedge clk);
    checkb("send_ready", cur_ready, m_phase != P_DONE);
    drv_data  = b;
    drv_valid = 1'b1;
    hs = cyc + 1;
    @(negedge clk);
    drv_valid = 1'b0;
    if (m_phase != P_DONE) model_byte(b, hs);
    last_hs = hs;
  endtask

  task automatic check_status(input string tag);
    model_settle();
    checkb({tag, "_done"},  cur_done,  m_phase == P_DONE);
    checkb({tag, "_err"},   cur_err,   m_phase == P_ERR);
    checkb({tag, "_crst"},  cur_crst,  m_phase == P_DONE);
    checkb({tag, "_ready"}, cur_ready, m_phase != P_DONE);
  endtask

  task automatic check_writes(input string tag);
    int n_act;
    n_act = act_q.size() - act_rd;
    check({tag, "_wcount"}, 32'(n_act), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n_act; i++) begin
      check({tag, "_waddr"}, 32'(act_q[act_rd + i].addr), 32'(exp_q[i].addr));
      check({tag, "_wdata"}, 32'(act_q[act_rd + i].data), 32'(exp_q[i].data));
      check({tag, "_wcyc"},  32'(act_q[act_rd + i].cyc),  32'(exp_q[i].cyc));
    end
    check({tag, "_stray"}, 32'(stray - stray_base), 32'd0);
    act_rd = act_q.size();
    exp_q.delete();
    stray_base = stray;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fr[$];
    logic [7:0] sum, c, nb;
    logic       s;
    int         len, nframes, h;

    sel = 1'b0; drv_valid = 1'b0; drv_data = 8'h00;
    arst_n = 1'b1;
    #2 arst_n = 1'b0;
    model_reset(1'b0);

    // reset values
    @(negedge clk); @(negedge clk);
    checkb("rst_ready",  if_a.rx_ready, 1'b0);
    check ("rst_addr_a", 32'(if_a.mem_addr), 32'h00);
    check ("rst_addr_b", 32'(if_b.mem_addr), 32'h80);
    checkb("rst_wen",    if_a.mem_write_en, 1'b0);
    check ("rst_data",   32'(if_a.mem_data), 32'h00);
    checkb("rst_crst",   core_rst_n_a, 1'b0);
    checkb("rst_done",   load_done_a, 1'b0);
    checkb("rst_err",    load_err_a, 1'b0);
    #1 arst_n = 1'b1;
    @(negedge clk);
    checkb("rst_ready_after_a", if_a.rx_ready, 1'b1);
    checkb("rst_ready_after_b", if_b.rx_ready, 1'b1);

    // 1: good frame, continuous
    do_reset(1'b0);
    send(8'hA5, 0); send(8'h03, 0); send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h9A, 0);
    repeat (2) @(negedge clk);
    check_writes("t1");
    check_status("t1");
    checkb("t1_done_lit", cur_done, 1'b1);

    // 2: bad checksum then a good reload
    do_reset(1'b0);
    send(8'hA5, 0); send(8'h02, 0); send(8'h10, 0); send(8'h20, 0); send(8'h00, 0);
    repeat (2) @(negedge clk);
    check_status("t2_bad");
    checkb("t2_err_lit", cur_err, 1'b1);
    send(8'hA5, 0);
    @(negedge clk);
    checkb("t2_err_cleared", cur_err, 1'b0);
    send(8'h01, 0); send(8'h05, 0); send(8'hFB, 0);
    repeat (2) @(negedge clk);
    check_writes("t2");
    check_status("t2_good");

    // 3: LEN=0 at base 80, address wrap
    do_reset(1'b1);
    send(8'hA5, 0); send(8'h00, 0);
    for (int i = 0; i < 256; i++) send(8'(i), 0);
    send(8'h80, 0);
    repeat (2) @(negedge clk);
    check_writes("t3");
    check_status("t3");

    // 4: timeout of 10 idle cycles
    do_reset(1'b0);
    send(8'hA5, 0); send(8'h04, 0); send(8'h01, 0);
    h = last_hs;
    while (cyc < h + 9) @(negedge clk);
    checkb("t4_err_before", cur_err, 1'b0);
    @(negedge clk);
    checkb("t4_err_at", cur_err, 1'b1);
    repeat (3) @(negedge clk);
    check_writes("t4");
    check_status("t4");

    // 5: noise bytes and a stall
    do_reset(1'b0);
    send(8'h00, 0); send(8'hFF, 0); send(8'hA5, 0); send(8'h01, 0); send(8'h7E, 3); send(8'h82, 0);
    repeat (2) @(negedge clk);
    check_writes("t5");
    check_status("t5");

    // 6: reset during DATA
    do_reset(1'b0);
    send(8'hA5, 0); send(8'h04, 0); send(8'h01, 0); send(8'h02, 0);
    #1;
    checkb("t6_wen_before", cur_wen, 1'b1);
    arst_n = 1'b0;
    #1;
    checkb("t6_wen_rst",   cur_wen, 1'b0);
    checkb("t6_crst_rst",  cur_crst, 1'b0);
    checkb("t6_ready_rst", cur_ready, 1'b0);
    check ("t6_addr_rst",  32'(cur_addr), 32'h00);
    model_reset(1'b0);
    @(negedge clk);
    #1 arst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_status("t6_idle");
    send(8'hA5, 0); send(8'h01, 0); send(8'h05, 0); send(8'hFB, 0);
    repeat (2) @(negedge clk);
    check_writes("t6");
    check_status("t6_reload");

    // randomized frames with noise, bad checksums and occasional long gaps
    for (int it = 0; it < 24; it++) begin
      s = 1'($urandom_range(0, 1));
      do_reset(s);
      repeat ($urandom_range(0, 2)) begin
        nb = 8'($urandom);
        if (nb == 8'hA5) nb = 8'h5A;
        send(nb, $urandom_range(0, 2));
      end
      nframes = $urandom_range(1, 2);
      for (int f = 0; f < nframes; f++) begin
        fr.delete();
        len = $urandom_range(1, 6);
        fr.push_back(8'hA5);
        fr.push_back(8'(len));
        sum = 8'h00;
        for (int k = 0; k < len; k++) begin
          nb = 8'($urandom);
          fr.push_back(nb);
          sum = sum + nb;
        end
        c = 8'h00 - sum;
        if ($urandom_range(0, 2) == 0) c = c ^ 8'h01;
        fr.push_back(c);
        foreach (fr[k]) begin
          if (m_phase != P_DONE)
            send(fr[k], ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 12)) : int'($urandom_range(0, 2)));
        end
      end
      repeat (12) @(negedge clk);
      check_status("rand");
      check_writes("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
